decode_stage: RTL and testbench
===============================

# decode_stage

Pipelined, parametrised instruction-decode stage with valid/ready handshakes on both sides and a per-register pending-write scoreboard. It sits between fetch and execute. Each cycle it can accept one 32-bit instruction, decode fields, immediate and ALU control, and register the result into an output slot. Issue stalls on read-after-write and write-saturation hazards; a flush input discards the in-flight decode.

## Interface
- `XLEN`, default 32: datapath width for PC and immediate (legal: 32, 64); immediates sign-extend to `XLEN`.
- `REG_ADDR_W`, default 5: register-address width; scoreboard has `2**REG_ADDR_W` entries.
- `CNT_W`, default 2: pending-write counter width per register; saturation value `2**CNT_W-1`.
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-low; `reset==0` at a rising edge clears all state.
- `in_valid` in 1: fetch offers `in_instr`/`in_pc`.
- `in_ready` out 1: stage accepts this cycle.
- `in_instr` in 32: instruction word.
- `in_pc` in `XLEN`: instruction address.
- `wb_valid` in 1: a register write retires this cycle.
- `wb_rd` in `REG_ADDR_W`: destination of the retiring write.
- `flush` in 1: kill the output slot and refuse input this cycle.
- `out_valid` out 1: decoded instruction available.
- `out_ready` in 1: execute accepts.
- `out_opcode` out 7 (`opcode_t`); `out_alu_control` out 4; `out_rs1`, `out_rs2`, `out_rd` out `REG_ADDR_W` each; `out_imm` out `XLEN`; `out_pc` out `XLEN`; `out_reg_write` out 1; `out_illegal` out 1.

## Operation
- Supported opcodes: RType, IType_logic, IType_load, IType_jalr (1100111), SType, BType, JType, UType_lui, UType_auipc. Any other opcode is illegal.
- Field use:
  - rs1 is used by R, I, jalr, S and B; rs2 by R, S and B.
  - rd and `reg_write=1` apply to R, I, jalr, J and U. `reg_write` is forced 0 when rd==0.
  - Unused register fields are driven 0.
- Immediates follow the I, S, B, J and U formats, sign-extended to `XLEN`. The U immediate is `instr[31:12]<<12`, sign-extended above bit 31.
- ALU op mapping:
  - R gives REGISTER_OPERATION; B gives BRANCH.
  - load, S, jalr, lui and auipc give MEMORY_ACCESS (add).
  - IType_logic passes funct3/funct7 to the ALU decoder as R does.
  - Everything else gives UNSET.
- Illegal instruction: `out_illegal=1`; rs1, rs2, rd, imm and `reg_write` are 0. It still flows through the handshake.
- Scoreboard `cnt[r]`:
  - `hazard = (uses_rs1 && rs1!=0 && cnt[rs1]!=0) || (uses_rs2 && rs2!=0 && cnt[rs2]!=0) || (reg_write && cnt[rd]==max)`.
  - `in_ready = reset && !flush && !hazard && (!out_valid || out_ready)`.
  - On accept (`in_valid && in_ready`), `cnt[rd]` increments if `reg_write`.
  - On `wb_valid && wb_rd!=0`, `cnt[wb_rd]` decrements.
  - Increment and decrement on the same register in the same cycle leave it unchanged.
  - A decrement at 0 holds at 0; the bench asserts this never happens.
- Flush when the slot is valid and `out_ready==0`: clear `out_valid` and decrement `cnt[out_rd]` if `out_reg_write`. This combines with a same-cycle writeback to the same register (net −2, floor 0).
- Flush while `out_valid && out_ready`: the transfer completes and nothing is undone.

## Timing
- Reset: `out_valid` and all `out_*` outputs are 0, all `cnt` are 0, and `in_ready` is 0 while `reset==0`.
- Latency is 1 cycle from accept to `out_valid`. Throughput is one instruction per cycle with no hazards and `out_ready` held high.
- `in_ready` is combinational from `out_ready`, `flush`, `wb_*` (via `cnt` only, registered) and `in_instr`. It does not depend on `in_valid`.
- Output slot behaviour:
  - It holds stable while `out_valid && !out_ready`.
  - On transfer with a simultaneous accept, the slot reloads the same cycle.
  - On transfer without an accept, `out_valid` drops.
- A writeback clears a hazard in the following cycle; there is no same-cycle bypass.

## Structure
- Shared package (`types.svh` / `params.vh`):
  - Existing: `opcode_t`, `alu_op_t`, `imm_t`.
  - Add to `opcode_t`: `IType_jalr`.
  - New: `instr_fmt_t` enum (R, I, S, B, U, J, ILLEGAL).
- Sub-module `instr_fields` is combinational: instr in; fmt, rs1, rs2, rd, use flags, `reg_write`, imm, funct3/funct7, `alu_op` out.
- Reuse the existing `ALUdecoder`.
- Scoreboard counters and the output slot live in `decode_stage`.

## Test plan
- Stream `addi x1,x0,5` (0x00500093) then `add x2,x1,x1` (0x00108133), `out_ready=1`:
  - the addi appears 1 cycle after accept with `out_imm=5`, `out_rd=1`;
  - the add stalls (`in_ready=0`) until `wb_valid` with `wb_rd=1`, then issues the next cycle.
- Decoded-field checks:
  - `sw x2,-4(x1)` (0xFE20AE23) gives `out_imm=0xFFFFFFFC`, `out_reg_write=0`, `out_rd=0`.
  - With XLEN=64, `lui x3,0x80000` gives `out_imm=0xFFFFFFFF80000000`.
- Backpressure: `out_ready=0` for 3 cycles with `in_valid=1` gives `in_ready=0` and stable outputs; on release, both instructions emerge in order with no loss or duplication.
- CNT_W=2: issue 3 independent writes to x5 with no writeback. The fourth write to x5 stalls; `wb_rd=5` in the same cycle as an accept to x5 keeps `cnt[5]` unchanged.
- Flush/reset/illegal:
  - `flush` with a held slot writing x7 and `out_ready=0` gives `out_valid=0` next cycle and `cnt[7]` back to its prior value.
  - `reset=0` mid-stream clears everything.
  - Opcode 0x7F gives `out_illegal=1`, `out_imm=0`.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode types: opcodes, ALU operation classes, instruction formats
// and the ALU control decoder used by the decode stage.
package decode_stage_pkg;

  typedef enum logic [6:0] {
    RType       = 7'b0110011,
    IType_logic = 7'b0010011,
    IType_load  = 7'b0000011,
    IType_jalr  = 7'b1100111,
    SType       = 7'b0100011,
    BType       = 7'b1100011,
    JType       = 7'b1101111,
    UType_lui   = 7'b0110111,
    UType_auipc = 7'b0010111
  } opcode_t;

  typedef enum logic [1:0] {
    MEMORY_ACCESS,
    BRANCH,
    REGISTER_OPERATION,
    UNSET
  } alu_op_t;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILLEGAL
  } instr_fmt_t;

  typedef logic [31:0] imm_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;
  localparam logic [3:0] ALU_NOP = 4'b1111;

  // Register ops encode {alternate-op flag, funct3}; only funct7=0x20 selects the alternate op.
  function automatic logic [3:0] alu_decoder(input alu_op_t op, input logic [2:0] funct3,
                                             input logic [6:0] funct7);
    case (op)
      MEMORY_ACCESS:      return ALU_ADD;
      BRANCH:             return ALU_SUB;
      REGISTER_OPERATION: return {funct7 == 7'b0100000, funct3};
      default:            return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_instr_fields.sv
// Combinational field extraction: format, register fields with use flags,
// 32-bit immediate, funct fields and ALU operation class.
module instr_fields
  import decode_stage_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [31:0]           instr,
  output instr_fmt_t            fmt,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic                  uses_rs1,
  output logic                  uses_rs2,
  output logic                  reg_write,
  output imm_t                  imm,
  output logic [2:0]            funct3,
  output logic [6:0]            funct7,
  output alu_op_t               alu_op
);

  logic has_rd;

  always_comb begin
    fmt      = FMT_ILLEGAL;
    alu_op   = UNSET;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    has_rd   = 1'b0;
    case (instr[6:0])
      RType:       begin fmt = FMT_R; alu_op = REGISTER_OPERATION; uses_rs1 = 1'b1; uses_rs2 = 1'b1; has_rd = 1'b1; end
      IType_logic: begin fmt = FMT_I; alu_op = REGISTER_OPERATION; uses_rs1 = 1'b1; has_rd = 1'b1; end
      IType_load,
      IType_jalr:  begin fmt = FMT_I; alu_op = MEMORY_ACCESS; uses_rs1 = 1'b1; has_rd = 1'b1; end
      SType:       begin fmt = FMT_S; alu_op = MEMORY_ACCESS; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      BType:       begin fmt = FMT_B; alu_op = BRANCH; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      JType:       begin fmt = FMT_J; has_rd = 1'b1; end
      UType_lui,
      UType_auipc: begin fmt = FMT_U; alu_op = MEMORY_ACCESS; has_rd = 1'b1; end
      default:     ;
    endcase
  end

  always_comb begin
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_U:   imm = {instr[31:12], 12'b0};
      default: imm = '0;
    endcase
  end

  // Unused register fields read as 0 so the hazard check never sees stale bits.
  assign rs1       = uses_rs1 ? REG_ADDR_W'(instr[19:15]) : '0;
  assign rs2       = uses_rs2 ? REG_ADDR_W'(instr[24:20]) : '0;
  assign rd        = has_rd   ? REG_ADDR_W'(instr[11:7])  : '0;
  assign reg_write = has_rd && (rd != '0);
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry output slot between fetch and execute, with a
// per-register pending-write counter scoreboard gating issue.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_instr,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output opcode_t               out_opcode,
  output logic [3:0]            out_alu_control,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [XLEN-1:0]       out_imm,
  output logic [XLEN-1:0]       out_pc,
  output logic                  out_reg_write,
  output logic                  out_illegal
);

  localparam int NREG = 2 ** REG_ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  instr_fmt_t            fmt;
  logic [REG_ADDR_W-1:0] rs1, rs2, rd;
  logic                  uses_rs1, uses_rs2, reg_write;
  imm_t                  imm;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  alu_op_t               alu_op;

  logic [CNT_W-1:0] cnt [NREG];
  logic hazard, accept, kill;

  instr_fields #(.REG_ADDR_W(REG_ADDR_W)) u_fields (
    .instr(in_instr), .fmt(fmt), .rs1(rs1), .rs2(rs2), .rd(rd),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .reg_write(reg_write),
    .imm(imm), .funct3(funct3), .funct7(funct7), .alu_op(alu_op)
  );

  // Handshake: a beat moves on a side only in a cycle where valid && ready at the
  // rising edge; in_ready never looks at in_valid, and the slot holds while
  // out_valid && !out_ready unless flush kills it.
  assign hazard = (uses_rs1 && rs1 != '0 && cnt[rs1] != '0) ||
                  (uses_rs2 && rs2 != '0 && cnt[rs2] != '0) ||
                  (reg_write && cnt[rd] == CNT_MAX);
  assign in_ready = reset && !flush && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign kill     = flush && out_valid && !out_ready;

  // Up by at most one, down by up to two (writeback plus killed slot), floored at 0.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] c, input logic inc,
                                                input logic [1:0] dec);
    logic [CNT_W+1:0] up, dn;
    up = {2'b00, c} + (CNT_W+2)'(inc);
    dn = (CNT_W+2)'(dec);
    return (up > dn) ? CNT_W'(up - dn) : '0;
  endfunction

  always_ff @(posedge clk) begin
    for (int r = 0; r < NREG; r++) begin
      if (!reset) cnt[r] <= '0;
      else cnt[r] <= cnt_step(cnt[r],
                              accept && reg_write && rd == REG_ADDR_W'(r),
                              2'(wb_valid && wb_rd != '0 && wb_rd == REG_ADDR_W'(r)) +
                              2'(kill && out_reg_write && out_rd == REG_ADDR_W'(r)));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid       <= 1'b0;
      out_opcode      <= opcode_t'(7'b0);
      out_alu_control <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      out_rd          <= '0;
      out_imm         <= '0;
      out_pc          <= '0;
      out_reg_write   <= 1'b0;
      out_illegal     <= 1'b0;
    end else if (kill) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid       <= 1'b1;
      out_opcode      <= opcode_t'(in_instr[6:0]);
      out_alu_control <= alu_decoder(alu_op, funct3, funct7);
      out_rs1         <= rs1;
      out_rs2         <= rs2;
      out_rd          <= rd;
      out_imm         <= XLEN'($signed(imm));
      out_pc          <= in_pc;
      out_reg_write   <= reg_write;
      out_illegal     <= (fmt == FMT_ILLEGAL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: scenario tasks with inline checks, plus a monitor that
// scores every output transfer against an expected queue filled on accept.
module tb_decode_stage;

  localparam int W = 92;
  localparam logic [31:0] ADDI_X1 = 32'h00500093;
  localparam logic [31:0] ADD_X2  = 32'h00108133;
  localparam logic [31:0] SW_I    = 32'hFE20AE23;
  localparam logic [31:0] LUI_I   = 32'h800001B7;
  localparam logic [31:0] ILL_I   = 32'h0000007F;
  localparam logic [31:0] FLD [10] = '{SW_I, LUI_I, 32'h00000463, 32'h0080026F, 32'h00001297,
                                       32'hFFC30367, 32'h40A3D393, ILL_I, 32'h40B50533, 32'h0000A183};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [6:0]  out_opcode;
  logic [3:0]  out_alu_control;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm, out_pc;
  logic        out_reg_write, out_illegal;

  logic        in_ready64, out_valid64, out_reg_write64, out_illegal64;
  logic [6:0]  out_opcode64;
  logic [3:0]  out_alu_control64;
  logic [4:0]  out_rs1_64, out_rs2_64, out_rd64;
  logic [63:0] out_imm64, out_pc64;

  int n_cmp = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v, obs_v;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_pc(in_pc), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_opcode(out_opcode), .out_alu_control(out_alu_control),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc),
    .out_reg_write(out_reg_write), .out_illegal(out_illegal)
  );

  decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr),
    .in_pc({32'h0, in_pc}), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .out_valid(out_valid64), .out_ready(out_ready), .out_opcode(out_opcode64),
    .out_alu_control(out_alu_control64), .out_rs1(out_rs1_64), .out_rs2(out_rs2_64),
    .out_rd(out_rd64), .out_imm(out_imm64), .out_pc(out_pc64),
    .out_reg_write(out_reg_write64), .out_illegal(out_illegal64)
  );

  // Reference decode written from the instruction-set encodings.
  function automatic logic [W-1:0] model_decode(input logic [31:0] ins, input logic [31:0] pc);
    logic [4:0] r1, r2, d;
    logic [31:0] im;
    logic [3:0] alu;
    logic legal, writes;
    r1 = ins[19:15]; r2 = ins[24:20]; d = ins[11:7]; im = '0; alu = 4'hF;
    legal = 1'b1; writes = 1'b1;
    case (ins[6:0])
      7'h33: alu = {ins[31:25] == 7'h20, ins[14:12]};
      7'h13: begin r2 = '0; im = {{20{ins[31]}}, ins[31:20]}; alu = {ins[31:25] == 7'h20, ins[14:12]}; end
      7'h03, 7'h67: begin r2 = '0; im = {{20{ins[31]}}, ins[31:20]}; alu = 4'h0; end
      7'h23: begin d = '0; writes = 1'b0; im = {{20{ins[31]}}, ins[31:25], ins[11:7]}; alu = 4'h0; end
      7'h63: begin d = '0; writes = 1'b0; alu = 4'h8;
                   im = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'h6F: begin r1 = '0; r2 = '0; im = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'h37, 7'h17: begin r1 = '0; r2 = '0; im = {ins[31:12], 12'h000}; alu = 4'h0; end
      default: begin legal = 1'b0; writes = 1'b0; r1 = '0; r2 = '0; d = '0; end
    endcase
    return {ins[6:0], alu, r1, r2, d, im, pc, writes && d != 5'd0, !legal};
  endfunction

  always @(negedge clk) begin
    if (!reset) exp_q.delete();
    else begin
      if (out_valid && out_ready) begin
        n_cmp++;
        obs_v = {out_opcode, out_alu_control, out_rs1, out_rs2, out_rd, out_imm, out_pc,
                 out_reg_write, out_illegal};
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL sb_unexpected: got %h required no transfer", obs_v);
        end else begin
          exp_v = exp_q.pop_front();
          if (obs_v !== exp_v) begin n_fail++; $display("FAIL sb_output: got %h required %h", obs_v, exp_v); end
        end
      end else if (flush && out_valid && exp_q.size() != 0) begin
        exp_v = exp_q.pop_front();
      end
      if (in_valid && in_ready) exp_q.push_back(model_decode(in_instr, in_pc));
    end
  end

  always @(negedge clk) begin
    if (reset && wb_valid && wb_rd != 5'd0) begin
      n_cmp++;
      if (dut.cnt[wb_rd] === 2'd0) begin n_fail++; $display("FAIL wb_at_zero: cnt[%0d] got 0 required nonzero", wb_rd); end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_wb(input logic [4:0] r);
    wb_valid = 1'b1; wb_rd = r; cyc(); wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b1; in_instr = ADDI_X1; out_ready = 1'b1;
    repeat (2) cyc();
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    n_cmp++; if ({out_imm, out_pc, out_rd} !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h %h %h required 0", out_imm, out_pc, out_rd); end
    n_cmp++; if (dut.cnt[1] !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d required 0", dut.cnt[1]); end
    cyc(); reset = 1'b1; in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_raw_hazard();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = ADDI_X1; in_pc = 32'h100;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_addi_ready: got %b required 1", in_ready); end
    cyc(); in_instr = ADD_X2; in_pc = 32'h104;
    @(negedge clk);
    n_cmp++; if ({out_valid, out_imm, out_rd} !== {1'b1, 32'd5, 5'd1}) begin
      n_fail++; $display("FAIL raw_addi_out: got v=%b imm=%h rd=%0d required v=1 imm=5 rd=1", out_valid, out_imm, out_rd); end
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall: got %b required 0", in_ready); end
    repeat (2) begin
      cyc(); @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_stall_hold: got %b required 0", in_ready); end
    end
    cyc(); wb_valid = 1'b1; wb_rd = 5'd1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL raw_no_bypass: got %b required 0", in_ready); end
    cyc(); wb_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL raw_release: got %b required 1", in_ready); end
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({out_valid, out_rd} !== {1'b1, 5'd2}) begin n_fail++; $display("FAIL raw_add_out: got v=%b rd=%0d required v=1 rd=2", out_valid, out_rd); end
    cyc(); do_wb(5'd2);
  endtask

  task automatic test_fields();
    out_ready = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      in_valid = (i < 10);
      if (i < 10) begin in_instr = FLD[i]; in_pc = 32'h200 + 32'(4 * i); end
      @(negedge clk);
      if (i < 10) begin
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL fields_throughput[%0d]: got %b required 1", i, in_ready); end
      end
      if (i > 0 && FLD[i-1] == SW_I) begin
        n_cmp++; if ({out_imm, out_reg_write, out_rd} !== {32'hFFFFFFFC, 1'b0, 5'd0}) begin
          n_fail++; $display("FAIL fields_sw: got imm=%h rw=%b rd=%0d required imm=fffffffc rw=0 rd=0", out_imm, out_reg_write, out_rd); end
      end
      if (i > 0 && FLD[i-1] == LUI_I) begin
        n_cmp++; if (out_imm64 !== 64'hFFFFFFFF80000000) begin n_fail++; $display("FAIL fields_lui64: got %h required ffffffff80000000", out_imm64); end
      end
      if (i > 0 && FLD[i-1] == ILL_I) begin
        n_cmp++; if ({out_illegal, out_imm} !== {1'b1, 32'd0}) begin n_fail++; $display("FAIL fields_illegal: got ill=%b imm=%h required ill=1 imm=0", out_illegal, out_imm); end
      end
      cyc();
    end
    do_wb(5'd3); do_wb(5'd3); do_wb(5'd4); do_wb(5'd5); do_wb(5'd6); do_wb(5'd7); do_wb(5'd10);
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00100413; in_pc = 32'h300;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_first_ready: got %b required 1", in_ready); end
    cyc(); in_instr = 32'h00200493; in_pc = 32'h304; out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b required 0", in_ready); end
      n_cmp++; if ({out_valid, out_rd, out_imm, out_pc} !== {1'b1, 5'd8, 32'd1, 32'h300}) begin
        n_fail++; $display("FAIL bp_stable: got v=%b rd=%0d imm=%h pc=%h required v=1 rd=8 imm=1 pc=300", out_valid, out_rd, out_imm, out_pc); end
      cyc();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b required 1", in_ready); end
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({out_valid, out_rd} !== {1'b1, 5'd9}) begin n_fail++; $display("FAIL bp_second: got v=%b rd=%0d required v=1 rd=9", out_valid, out_rd); end
    cyc(); do_wb(5'd8); do_wb(5'd9);
  endtask

  task automatic test_saturation();
    out_ready = 1'b1; in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      in_instr = {12'(k), 20'h00293};
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_issue[%0d]: got %b required 1", k, in_ready); end
      cyc();
    end
    in_instr = 32'h00400293;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL sat_stall: got %b required 0", in_ready); end
    n_cmp++; if (dut.cnt[5] !== 2'd3) begin n_fail++; $display("FAIL sat_cnt_max: got %0d required 3", dut.cnt[5]); end
    cyc(); wb_valid = 1'b1; wb_rd = 5'd5;
    cyc(); wb_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_after_wb: got %b required 1", in_ready); end
    cyc(); in_valid = 1'b0;
    do_wb(5'd5);
    in_valid = 1'b1; in_instr = 32'h00500293; wb_valid = 1'b1; wb_rd = 5'd5;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sat_inc_dec_ready: got %b required 1", in_ready); end
    cyc(); in_valid = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (dut.cnt[5] !== 2'd2) begin n_fail++; $display("FAIL sat_inc_dec: got %0d required 2", dut.cnt[5]); end
    cyc(); do_wb(5'd5); do_wb(5'd5);
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00700393;
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (dut.cnt[7] !== 2'd1) begin n_fail++; $display("FAIL flush_pending: got %0d required 1", dut.cnt[7]); end
    cyc(); flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b required 0", in_ready); end
    cyc(); flush = 1'b0;
    @(negedge clk);
    n_cmp++; if ({out_valid, dut.cnt[7]} !== {1'b0, 2'd0}) begin n_fail++; $display("FAIL flush_kill: got v=%b cnt=%0d required v=0 cnt=0", out_valid, dut.cnt[7]); end
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00700393;
    cyc(); in_instr = 32'h00800393;
    cyc(); in_valid = 1'b0; out_ready = 1'b0;
    cyc(); flush = 1'b1; wb_valid = 1'b1; wb_rd = 5'd7;
    cyc(); flush = 1'b0; wb_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({out_valid, dut.cnt[7]} !== {1'b0, 2'd0}) begin n_fail++; $display("FAIL flush_with_wb: got v=%b cnt=%0d required v=0 cnt=0", out_valid, dut.cnt[7]); end
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h00C00613;
    cyc(); flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_xfer_ready: got %b required 0", in_ready); end
    cyc(); flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({out_valid, dut.cnt[12]} !== {1'b0, 2'd1}) begin n_fail++; $display("FAIL flush_xfer_kept: got v=%b cnt=%0d required v=0 cnt=1", out_valid, dut.cnt[12]); end
    cyc(); do_wb(5'd12);
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00D00693; in_pc = 32'h400;
    cyc(); in_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if ({out_valid, dut.cnt[13]} !== {1'b1, 2'd1}) begin n_fail++; $display("FAIL mid_setup: got v=%b cnt=%0d required v=1 cnt=1", out_valid, dut.cnt[13]); end
    cyc(); reset = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b required 0", in_ready); end
    cyc();
    @(negedge clk);
    n_cmp++; if ({out_valid, dut.cnt[13], out_rd, out_imm, out_pc} !== '0) begin
      n_fail++; $display("FAIL mid_cleared: got v=%b cnt=%0d rd=%0d imm=%h pc=%h required all 0", out_valid, dut.cnt[13], out_rd, out_imm, out_pc); end
    cyc(); reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: simulation got no end required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_raw_hazard();
    test_fields();
    test_backpressure();
    test_saturation();
    test_flush();
    test_reset_midstream();
    n_cmp++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_drain: got %0d left required 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
